// File: rtl/d_register_bank_if.sv
// d_register_bank_if: bus bundle for the d_register_bank storage block.
// Optional macro D_REGISTER_BANK_PARITY_EN adds the per-channel parity signal.
interface d_register_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [1:0]                mode;
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [WIDTH-1:0]          sin;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [WIDTH-1:0]          sout;
    logic [CHANNELS-1:0]       changed;
    logic [CHANNELS-1:0]       valid;
`ifdef D_REGISTER_BANK_PARITY_EN
    logic [CHANNELS-1:0]       parity;
`endif

    // Driver side: supplies mode, enables and data, observes stored state
    modport master (
        output mode, en, d, sin,
        input  q, sout, changed, valid
`ifdef D_REGISTER_BANK_PARITY_EN
        , input parity
`endif
    );

    // Register bank side
    modport slave (
        input  mode, en, d, sin,
        output q, sout, changed, valid
`ifdef D_REGISTER_BANK_PARITY_EN
        , output parity
`endif
    );
endinterface

// File: rtl/d_register_bank.sv
// d_register_bank: CHANNELS edge-triggered WIDTH-bit registers with hold, load,
// shift-chain and clear modes, plus per-channel changed/valid status flags.
// Optional macro D_REGISTER_BANK_PARITY_EN adds registered per-channel parity.
module d_register_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic               clk,
    input  logic               rst,
    d_register_bank_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    mode_e                     w_mode;
    logic [WIDTH-1:0]          r_data [CHANNELS];
    logic [WIDTH-1:0]          w_next [CHANNELS];
    logic [CHANNELS-1:0]       r_valid;
    logic [CHANNELS-1:0]       w_nextValid;
    logic [CHANNELS-1:0]       r_changed;
    logic [CHANNELS*WIDTH-1:0] w_qFlat;

    // Next-state selection for every channel; anything not written holds
    always_comb begin
        w_mode      = mode_e'(bus.mode);
        w_nextValid = r_valid;
        for (int k = 0; k < CHANNELS; k++) begin
            w_next[k] = r_data[k];
        end
        case (w_mode)
            MODE_LOAD: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (bus.en[k]) begin
                        w_next[k]      = bus.d[k*WIDTH +: WIDTH];
                        w_nextValid[k] = 1'b1;
                    end
                end
            end
            MODE_SHIFT: begin
                w_next[0]      = bus.sin;
                w_nextValid[0] = 1'b1;
                for (int k = 1; k < CHANNELS; k++) begin
                    w_next[k]      = r_data[k-1];
                    w_nextValid[k] = r_valid[k-1];
                end
            end
            MODE_CLEAR: begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (bus.en[k]) begin
                        w_next[k]      = '0;
                        w_nextValid[k] = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Data, valid and changed registers; changed compares new against old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_data[k] <= '0;
            end
            r_valid   <= '0;
            r_changed <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_data[k]    <= w_next[k];
                r_changed[k] <= (w_next[k] != r_data[k]);
            end
            r_valid <= w_nextValid;
        end
    end

`ifdef D_REGISTER_BANK_PARITY_EN
    logic [CHANNELS-1:0] r_parity;

    // Parity is taken from the next data so it lands on the same edge as q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                r_parity[k] <= ^w_next[k];
            end
        end
    end

    assign bus.parity = r_parity;
`endif

    // Pack channel registers onto the flat q bus, channel k at slice k
    always_comb begin
        w_qFlat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_qFlat[k*WIDTH +: WIDTH] = r_data[k];
        end
    end

    assign bus.q       = w_qFlat;
    assign bus.sout    = r_data[CHANNELS-1];
    assign bus.changed = r_changed;
    assign bus.valid   = r_valid;

endmodule

// File: tb/tb_d_register_bank.sv
// tb_d_register_bank: directed test of d_register_bank (WIDTH=8, CHANNELS=4)
// against a queue-based reference model, plus hand-computed checkpoints.
// Honours D_REGISTER_BANK_PARITY_EN when defined.
module tb_d_register_bank;

    logic clk;
    logic rst;
    int   numCompared;
    int   numMismatched;
    bit   checking;

    d_register_bank_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    d_register_bank #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: channel 0 at the queue front, the shift pushes sin in
    // at the front and drops the oldest word off the back
    logic [7:0] mQ[$];
    logic [7:0] oldQ[$];
    logic [3:0] mValid;
    logic [3:0] mChanged;

    initial begin
        mQ       = '{8'h00, 8'h00, 8'h00, 8'h00};
        mValid   = 4'b0000;
        mChanged = 4'b0000;
    end

    // Model update on each rising edge, or immediately on reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mQ       = '{8'h00, 8'h00, 8'h00, 8'h00};
            mValid   = 4'b0000;
            mChanged = 4'b0000;
        end else begin
            oldQ = mQ;
            case (bus.mode)
                2'b01: begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.en[k]) begin
                            mQ[k]     = bus.d[k*8 +: 8];
                            mValid[k] = 1'b1;
                        end
                    end
                end
                2'b10: begin
                    mQ.push_front(bus.sin);
                    void'(mQ.pop_back());
                    mValid = {mValid[2:0], 1'b1};
                end
                2'b11: begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.en[k]) begin
                            mQ[k]     = 8'h00;
                            mValid[k] = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
            for (int k = 0; k < 4; k++) begin
                mChanged[k] = (mQ[k] != oldQ[k]);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, return at the falling edge
    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] e,
                                 input logic [31:0] dv, input logic [7:0] s);
        bus.mode = m;
        bus.en   = e;
        bus.d    = dv;
        bus.sin  = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (checking) begin
            logic [31:0] expQ;
            logic [3:0]  expParity;
            for (int k = 0; k < 4; k++) begin
                expQ[k*8 +: 8] = mQ[k];
                expParity[k]   = ^mQ[k];
            end
            checkOutput("model_q", 64'(bus.q), 64'(expQ));
            checkOutput("model_valid", 64'(bus.valid), 64'(mValid));
            checkOutput("model_changed", 64'(bus.changed), 64'(mChanged));
            checkOutput("model_sout", 64'(bus.sout), 64'(mQ[3]));
`ifdef D_REGISTER_BANK_PARITY_EN
            checkOutput("model_parity", 64'(bus.parity), 64'(expParity));
`else
            if (expParity === 4'bxxxx) numCompared = numCompared;
`endif
        end
    end

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        checking      = 1'b0;
        rst           = 1'b1;
        bus.mode      = 2'b00;
        bus.en        = 4'b0000;
        bus.d         = 32'h0;
        bus.sin       = 8'h00;

        repeat (2) @(negedge clk);
        checking = 1'b1;
        checkOutput("reset_q", 64'(bus.q), 64'h0);
        checkOutput("reset_valid", 64'(bus.valid), 64'h0);
        rst = 1'b0;

        // Selective load of channels 0 and 2
        applyStimulus(2'b01, 4'b0101, 32'h44332211, 8'h00);
        checkOutput("sel_load_q", 64'(bus.q), 64'h00330011);
        checkOutput("sel_load_valid", 64'(bus.valid), 64'b0101);
        checkOutput("sel_load_changed", 64'(bus.changed), 64'b0101);
        applyStimulus(2'b00, 4'b1111, 32'hDEADBEEF, 8'hEE);
        checkOutput("hold_changed", 64'(bus.changed), 64'b0000);

        // Writing the same value twice only flags the first write
        applyStimulus(2'b01, 4'b0100, 32'h115A2233, 8'h00);
        checkOutput("idem_first_q", 64'(bus.q), 64'h005A0011);
        checkOutput("idem_first_changed", 64'(bus.changed), 64'b0100);
        applyStimulus(2'b01, 4'b0100, 32'h995A8877, 8'h00);
        checkOutput("idem_second_changed", 64'(bus.changed), 64'b0000);

        // Clear of channel 3 only
        applyStimulus(2'b01, 4'b1111, 32'h77777777, 8'h00);
        applyStimulus(2'b11, 4'b1000, 32'hFFFFFFFF, 8'hFF);
        checkOutput("clear_q", 64'(bus.q), 64'h00777777);
        checkOutput("clear_valid", 64'(bus.valid), 64'b0111);
        checkOutput("clear_changed", 64'(bus.changed), 64'b1000);
        applyStimulus(2'b00, 4'b0000, 32'h0, 8'h00);
        checkOutput("clear_hold_changed", 64'(bus.changed), 64'b0000);

        // Load and clear with no enables behave as hold
        applyStimulus(2'b01, 4'b0000, 32'h12345678, 8'h00);
        checkOutput("load_en0_q", 64'(bus.q), 64'h00777777);
        applyStimulus(2'b11, 4'b0000, 32'h0, 8'h00);
        checkOutput("clear_en0_changed", 64'(bus.changed), 64'b0000);

        // Asynchronous reset between edges after loading all 0xFF
        applyStimulus(2'b01, 4'b1111, 32'hFFFFFFFF, 8'h00);
        checkOutput("ff_changed", 64'(bus.changed), 64'b1111);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_q", 64'(bus.q), 64'h0);
        checkOutput("async_valid", 64'(bus.valid), 64'h0);
        checkOutput("async_changed", 64'(bus.changed), 64'h0);
        #1 rst = 1'b0;

        // Shift chain of five words from reset
        applyStimulus(2'b10, 4'b0000, 32'h0, 8'hA1);
        applyStimulus(2'b10, 4'b1111, 32'h0, 8'hA2);
        applyStimulus(2'b10, 4'b0000, 32'h0, 8'hA3);
        applyStimulus(2'b10, 4'b0000, 32'h0, 8'hA4);
        checkOutput("shift_sout_before5", 64'(bus.sout), 64'hA1);
        applyStimulus(2'b10, 4'b0000, 32'h0, 8'hA5);
        checkOutput("shift_q", 64'(bus.q), 64'hA2A3A4A5);
        checkOutput("shift_valid", 64'(bus.valid), 64'b1111);
        checkOutput("shift_sout", 64'(bus.sout), 64'hA2);

`ifdef D_REGISTER_BANK_PARITY_EN
        // Parity follows data through a load and a shift
        applyStimulus(2'b01, 4'b0011, 32'h00000307, 8'h00);
        checkOutput("parity_load", 64'(bus.parity[1:0]), 64'b01);
        applyStimulus(2'b10, 4'b0000, 32'h0, 8'h00);
        checkOutput("parity_shift", 64'(bus.parity[1]), 64'b1);
`endif

        applyStimulus(2'b00, 4'b0000, 32'h0, 8'h00);
        checking = 1'b0;
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
